// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch unit
package fetch_pkg;
    localparam int INST_W = 32;
    localparam int PC_INC = 4;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH, FLUSH} fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [63:0]       pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous ring-buffer FIFO with flush and occupancy count
//   push/din   write din when push (caller guarantees room, or a same-cycle pop)
//   pop/dout   dout is the head entry; pop advances it (caller guarantees non-empty)
//   flush      empties the FIFO, overriding push/pop
//   full/empty/count  occupancy status
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation, in-order imem requests and decode-side buffering
//   imem_req_*      request channel (addr = pc), credit-limited to DEPTH outstanding+buffered
//   imem_rsp_*      in-order responses, no backpressure
//   redirect_*      taken branch/jump pulse; flushes buffer and discards in-flight fetches
//   inst_*          {instruction, pc} to decode over valid/ready
//   inv_pc          sticky flag: a redirect target was not 4-byte aligned
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inv_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, q_pc;
    logic [CW-1:0]     inflight, occ, drop;
    logic [CW-1:0]     inflight_next, occ_next, drop_next;
    logic              req_fire, keep, pop, req_valid_next;
    logic              q_full, q_empty, b_full, b_empty;

    assign imem_req_addr = pc;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign pop           = inst_valid && inst_ready;
    // A response is buffered only when no discards are owed and no redirect kills it.
    assign keep          = imem_rsp_valid && drop == '0 && !redirect_valid;
    assign inst_valid    = !b_empty;

    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_inflight_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .din   (pc),
        .dout  (q_pc),
        .full  (q_full),
        .empty (q_empty),
        .count (inflight)
    );

    fetch_fifo #(.W(INST_W + ADDR_W), .DEPTH(DEPTH)) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_rsp_data, q_pc}),
        .dout  ({inst_out, inst_pc}),
        .full  (b_full),
        .empty (b_empty),
        .count (occ)
    );

    // Next-state values let imem_req_valid be registered yet still equal the
    // credit rule evaluated on the current state.
    always_comb begin
        inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
        occ_next       = redirect_valid ? '0 : occ + CW'(keep) - CW'(pop);
        drop_next      = redirect_valid ? inflight_next
                                        : drop - CW'(imem_rsp_valid && drop != '0);
        state_next     = drop_next != '0 ? FLUSH : FETCH;
        pc_next        = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00}
                       : req_fire       ? pc + ADDR_W'(PC_INC) : pc;
        req_valid_next = state_next == FETCH
                      && (CW+1)'(inflight_next) + (CW+1)'(occ_next) < (CW+1)'(DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            drop           <= '0;
            inv_pc         <= 1'b0;
            imem_req_valid <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            drop           <= drop_next;
            inv_pc         <= inv_pc || (redirect_valid && redirect_pc[1:0] != 2'b00);
            imem_req_valid <= req_valid_next;
        end
    end

    a_inflight: assert property (@(posedge clk) disable iff (!rst_n) inflight <= CW'(DEPTH));
    a_occ:      assert property (@(posedge clk) disable iff (!rst_n) occ <= CW'(DEPTH));
    a_drop:     assert property (@(posedge clk) disable iff (!rst_n) drop <= inflight);
    a_flush:    assert property (@(posedge clk) disable iff (!rst_n) (state == FLUSH) == (drop != '0));
    a_q_room:   assert property (@(posedge clk) disable iff (!rst_n) req_fire |-> !q_full);
    a_q_rsp:    assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> !q_empty);
    a_b_room:   assert property (@(posedge clk) disable iff (!rst_n) keep |-> !b_full || pop);
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized self-checking bench against a queue-based fetch model
module tb_instruction_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        inv_pc;

    instruction_fetch #(.ADDR_W(64), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inv_pc         (inv_pc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] pc; bit stale;} infl_t;
    typedef struct {logic [31:0] inst; logic [63:0] pc;} ent_t;

    infl_t       infl[$];
    ent_t        bufq[$];
    logic [63:0] pc_m;
    bit          inv_m, started;
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    int          last_due, cyc;
    logic [63:0] req_log[$];
    logic [63:0] pop_log[$];
    int          total = 0, passed = 0;

    function automatic logic [31:0] mem(logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_out", inst_out, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inv_pc", inv_pc, 0);
        infl.delete();
        bufq.delete();
        pend_addr.delete();
        pend_due.delete();
        pc_m = 64'h0;
        inv_m = 0;
        started = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        last_due = -1;
    endtask

    // One clock cycle: compare DUT against the model, drive inputs, advance model.
    task automatic cycle(input bit rdy, input bit irdy, input bit redir,
                         input logic [63:0] rpc, input int lat);
        bit          exp_rv, stale_any, rsp, fire, pop;
        logic [31:0] rdata;
        logic [63:0] raddr;
        infl_t       f;
        int          due;
        stale_any = 0;
        foreach (infl[i]) if (infl[i].stale) stale_any = 1;
        exp_rv = started && !stale_any && infl.size() + bufq.size() < DEPTH;
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, pc_m);
        check("inst_valid", inst_valid, bufq.size() > 0);
        if (bufq.size() > 0) begin
            check("inst_out", inst_out, bufq[0].inst);
            check("inst_pc", inst_pc, bufq[0].pc);
        end
        check("inv_pc", inv_pc, inv_m);
        rsp = pend_due.size() > 0 && pend_due[0] <= cyc;
        rdata = $urandom;
        if (rsp) begin
            raddr = pend_addr.pop_front();
            void'(pend_due.pop_front());
            rdata = mem(raddr);
        end
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data = rdata;
        redirect_valid = redir;
        redirect_pc = rpc;
        inst_ready = irdy;
        fire = exp_rv && rdy;
        pop = bufq.size() > 0 && irdy;
        if (fire) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
            req_log.push_back(pc_m);
        end
        if (pop) pop_log.push_back(bufq[0].pc);
        f = '{64'h0, 1'b1};
        if (rsp && infl.size() > 0) f = infl.pop_front();
        if (redir) begin
            bufq.delete();
            foreach (infl[i]) infl[i].stale = 1;
            if (fire) infl.push_back('{pc_m, 1'b1});
            pc_m = {rpc[63:2], 2'b00};
            inv_m = inv_m || rpc[1:0] != 2'b00;
        end else begin
            if (pop) void'(bufq.pop_front());
            if (rsp && !f.stale) bufq.push_back('{rdata, f.pc});
            if (fire) begin
                infl.push_back('{pc_m, 1'b0});
                pc_m = pc_m + 64'd4;
            end
        end
        started = 1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] rpc;
        rst_n = 1'b1;
        cyc = 0;
        last_due = -1;
        #2;
        do_reset();

        clear_logs();
        repeat (14) cycle(1, 1, 0, 0, 1);
        check("p1_req0", req_log[0], 64'h0);
        check("p1_req1", req_log[1], 64'h4);
        check("p1_req2", req_log[2], 64'h8);
        check("p1_pop0", pop_log[0], 64'h0);
        check("p1_pop2", pop_log[2], 64'h8);

        do_reset();
        clear_logs();
        repeat (10) cycle(1, 0, 0, 0, 1);
        check("p2_req_count", req_log.size(), 2);
        check("p2_stalled_req_valid", imem_req_valid, 0);
        check("p2_head_pc", inst_pc, 64'h0);
        clear_logs();
        repeat (4) cycle(1, 1, 0, 0, 1);
        check("p2_drain0", pop_log[0], 64'h0);
        check("p2_drain1", pop_log[1], 64'h4);
        check("p2_resume", req_log[0], 64'h8);

        do_reset();
        repeat (3) cycle(1, 1, 0, 0, 3);
        check("p3_inflight", infl.size(), 2);
        cycle(1, 1, 1, 64'h100, 3);
        clear_logs();
        repeat (12) cycle(1, 1, 0, 0, 3);
        check("p3_first_inst", pop_log[0], 64'h100);
        check("p3_req0", req_log[0], 64'h100);
        check("p3_req1", req_log[1], 64'h104);

        do_reset();
        repeat (3) cycle(1, 1, 0, 0, 1);
        clear_logs();
        cycle(1, 1, 1, 64'h200, 1);
        check("p4_empty_after", inst_valid, 0);
        repeat (6) cycle(1, 1, 0, 0, 1);
        check("p4_head_consumed", pop_log[0], 64'h0);
        check("p4_target_inst", pop_log[1], 64'h200);

        cycle(1, 1, 1, 64'h102, 1);
        clear_logs();
        check("p5_inv_set", inv_pc, 1);
        repeat (8) cycle(1, 1, 0, 0, 1);
        check("p5_aligned_req", req_log[0], 64'h100);
        check("p5_inv_sticky", inv_pc, 1);

        repeat (3000) begin
            rpc = {$urandom, $urandom};
            if ($urandom % 4 == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
            cycle($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 20 == 0,
                  rpc, $urandom_range(1, 4));
        end

        repeat (6) cycle(1, 0, 0, 0, 1);
        check("p7_buf_full", inst_valid, 1);
        do_reset();
        clear_logs();
        repeat (3) cycle(1, 1, 0, 0, 1);
        check("p7_restart_pc", req_log[0], 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
